// File: rtl/sort_frame_ctrl_if.sv
// Sample input stream and rank-ordered output stream of sort_frame_ctrl.
// The master drives samples in and ready out; the slave is the controller.
interface sort_frame_ctrl_if #(
  parameter int DATA_W  = 20,
  parameter int SCORE_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [SCORE_W-1:0] out_rank;
  logic               out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_rank, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_rank, out_last
  );
endinterface

// File: rtl/sort_frame_ctrl.sv
// Frame sequencer for the parallel rank sorter: gathers COL_WIDTH samples,
// launches the sorter, scatters samples by returned rank and drains them in order.
module sort_frame_ctrl #(
  parameter int COL_WIDTH = 16,
  parameter int DATA_W    = 20,
  parameter int SCORE_W   = 8,
  parameter int TIMEOUT   = 64,
  parameter int DESCEND   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  sort_frame_ctrl_if.slave              bus,
  output logic [COL_WIDTH*DATA_W-1:0]   sort_data_o,
  output logic                          sort_valid_o,
  input  logic [COL_WIDTH*SCORE_W-1:0]  score_i,
  input  logic                          score_done_i,
  output logic                          err_pulse,
  output logic [1:0]                    err_code,
  output logic [15:0]                   frame_cnt
);
  localparam int IDX_W = $clog2(COL_WIDTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [SCORE_W-1:0] FIRST_RANK = (DESCEND != 0) ? SCORE_W'(COL_WIDTH) : SCORE_W'(1);
  localparam logic [SCORE_W-1:0] FINAL_RANK = (DESCEND != 0) ? SCORE_W'(1) : SCORE_W'(COL_WIDTH);

  typedef enum logic [1:0] {S_LOAD, S_LAUNCH, S_WAIT, S_DRAIN} state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 cnt_q, cnt_d;
  logic [COL_WIDTH-1:0][DATA_W-1:0] lane_q, lane_d;
  logic [COL_WIDTH-1:0][DATA_W-1:0] slot_q, slot_d;
  logic [TMR_W-1:0]                 timer_q, timer_d;
  logic                             sort_valid_q, sort_valid_d;
  logic                             err_pulse_q, err_pulse_d;
  logic [1:0]                       err_code_q, err_code_d;
  logic [15:0]                      frame_cnt_q, frame_cnt_d;
  logic                             out_valid_q, out_valid_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic [SCORE_W-1:0]               out_rank_q, out_rank_d;
  logic                             out_last_q, out_last_d;

  logic [COL_WIDTH-1:0][DATA_W-1:0] scat_s;
  logic [COL_WIDTH-1:0]             bitmap_s;
  logic                             range_bad_s;
  logic [SCORE_W-1:0]               score_s;
  logic [SCORE_W-1:0]               rank_next_s;

  // Ranks are 1-based; slot storage is 0-based.
  function automatic logic [IDX_W-1:0] rank_idx(input logic [SCORE_W-1:0] r);
    return IDX_W'(r - SCORE_W'(1));
  endfunction

  assign sort_data_o  = lane_q;
  assign sort_valid_o = sort_valid_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;
  assign frame_cnt    = frame_cnt_q;
  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rank  = out_rank_q;
  assign bus.out_last  = out_last_q;

  // Scatter every lane to its ranked slot and mark which ranks were seen.
  always_comb begin
    scat_s      = slot_q;
    bitmap_s    = '0;
    range_bad_s = 1'b0;
    score_s     = '0;
    for (int c = 0; c < COL_WIDTH; c++) begin
      score_s = score_i[c*SCORE_W +: SCORE_W];
      if ((score_s != '0) && (score_s <= SCORE_W'(COL_WIDTH))) begin
        scat_s[rank_idx(score_s)]   = lane_q[c];
        bitmap_s[rank_idx(score_s)] = 1'b1;
      end else begin
        range_bad_s = 1'b1;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    slot_d       = slot_q;
    timer_d      = timer_q;
    sort_valid_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_rank_d   = out_rank_q;
    out_last_d   = out_last_q;
    rank_next_s  = (DESCEND != 0) ? (out_rank_q - SCORE_W'(1)) : (out_rank_q + SCORE_W'(1));

    case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          lane_d[cnt_q] = bus.in_data;
          if (cnt_q == IDX_W'(COL_WIDTH - 1)) begin
            cnt_d        = '0;
            sort_valid_d = 1'b1;
            state_d      = S_LAUNCH;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LAUNCH: begin
        err_code_d = 2'd0;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A result arriving on the expiry cycle is still taken.
        if (score_done_i) begin
          slot_d = scat_s;
          if (range_bad_s || !(&bitmap_s)) begin
            err_code_d  = 2'd2;
            err_pulse_d = 1'b1;
            state_d     = S_LOAD;
          end else begin
            out_valid_d = 1'b1;
            out_rank_d  = FIRST_RANK;
            out_data_d  = scat_s[rank_idx(FIRST_RANK)];
            out_last_d  = (FIRST_RANK == FINAL_RANK);
            state_d     = S_DRAIN;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_code_d  = 2'd1;
          err_pulse_d = 1'b1;
          state_d     = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = S_LOAD;
          end else begin
            out_rank_d = rank_next_s;
            out_data_d = slot_q[rank_idx(rank_next_s)];
            out_last_d = (rank_next_s == FINAL_RANK);
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State and output registers; clr returns everything to the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      lane_q       <= '0;
      slot_q       <= '0;
      timer_q      <= '0;
      sort_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'd0;
      frame_cnt_q  <= 16'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rank_q   <= '0;
      out_last_q   <= 1'b0;
    end else if (clr) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      lane_q       <= '0;
      slot_q       <= '0;
      timer_q      <= '0;
      sort_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'd0;
      frame_cnt_q  <= 16'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_rank_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      slot_q       <= slot_d;
      timer_q      <= timer_d;
      sort_valid_q <= sort_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_rank_q   <= out_rank_d;
      out_last_q   <= out_last_d;
    end
  end
endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench: a DESCEND=1 and a DESCEND=0 controller share every stimulus,
// so each frame checks both output orders against a ranking model.
module tb_sort_frame_ctrl;
  localparam int CW = 16;
  localparam int DW = 20;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW*SW-1:0] score = '0;
  logic score_done = 1'b0;

  always #5 clk = ~clk;

  sort_frame_ctrl_if #(.DATA_W(DW), .SCORE_W(SW)) bus_a ();
  sort_frame_ctrl_if #(.DATA_W(DW), .SCORE_W(SW)) bus_b ();
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  logic [CW*DW-1:0] sd_a, sd_b;
  logic sv_a, sv_b, ep_a, ep_b;
  logic [1:0] ec_a, ec_b;
  logic [15:0] fc_a, fc_b;

  sort_frame_ctrl #(.COL_WIDTH(CW), .DATA_W(DW), .SCORE_W(SW), .TIMEOUT(64), .DESCEND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_a),
    .sort_data_o(sd_a), .sort_valid_o(sv_a), .score_i(score), .score_done_i(score_done),
    .err_pulse(ep_a), .err_code(ec_a), .frame_cnt(fc_a));

  sort_frame_ctrl #(.COL_WIDTH(CW), .DATA_W(DW), .SCORE_W(SW), .TIMEOUT(64), .DESCEND(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_b),
    .sort_data_o(sd_b), .sort_valid_o(sv_b), .score_i(score), .score_done_i(score_done),
    .err_pulse(ep_b), .err_code(ec_b), .frame_cnt(fc_b));

  // fault: 0 ok, 1 duplicate rank, 2 rank 0, 3 rank 17, 4 no score_done, 5 score_done on last wait cycle
  typedef struct {
    int          pat;
    int          fault;
    int          rmode;
    logic [1:0]  exp_err;
    logic [15:0] exp_cnt;
    logic [19:0] first_a;
    logic [19:0] last_a;
  } vec_t;

  vec_t tbl [9];
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] frm [CW];
  int rk [CW];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input int pat, input int c);
    case (pat)
      0:       return DW'((c + 1) * 16);
      1:       return DW'(20'hFFFFF - c);
      default: return DW'(((c * 7) % 16) * 273 + 5);
    endcase
  endfunction

  function automatic logic [DW-1:0] by_rank(input int r);
    for (int c = 0; c < CW; c++) if (rk[c] == r) return frm[c];
    return '0;
  endfunction

  task automatic run_frame(input vec_t v, input int rst_after);
    logic [CW*DW-1:0] pk;
    logic [CW*SW-1:0] sc;
    int t, k, cyc, d;
    for (int c = 0; c < CW; c++) begin
      frm[c] = pat_val(v.pat, c);
      pk[c*DW +: DW] = frm[c];
    end
    for (int c = 0; c < CW; c++) begin
      rk[c] = 1;
      for (int j = 0; j < CW; j++) if (frm[j] < frm[c]) rk[c]++;
      sc[c*SW +: SW] = SW'(rk[c]);
    end
    case (v.fault)
      1: begin sc[2*SW +: SW] = 8'd5; sc[6*SW +: SW] = 8'd5; end
      2: sc[0 +: SW] = 8'd0;
      3: sc[0 +: SW] = 8'd17;
      default: ;
    endcase
    // Load with two bubbles.
    for (int c = 0; c < CW; c++) begin
      @(negedge clk);
      if (c == 5 || c == 11) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data = frm[c];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("launch_a", sv_a, 1'b1);
    chk("launch_b", sv_b, 1'b1);
    chk("in_ready_launch", bus_a.in_ready, 1'b0);
    chk("frame_a", sd_a, pk);
    @(negedge clk);
    t = 1;
    chk("launch_one_cycle", sv_a, 1'b0);
    chk("err_clear_a", ec_a, 2'd0);
    chk("err_clear_b", ec_b, 2'd0);
    chk("frame_b_hold", sd_b, pk);
    if (v.fault == 4) begin
      // Sorter gets 64 wait cycles; the abort is registered one cycle later.
      while (!ep_a && t < 200) begin @(negedge clk); t++; end
      chk("timeout_cycle", t, 65);
      chk("timeout_code_a", ec_a, 2'd1);
      chk("timeout_code_b", ec_b, 2'd1);
      chk("timeout_pulse_b", ep_b, 1'b1);
      chk("timeout_in_ready", bus_a.in_ready, 1'b1);
      chk("timeout_cnt", fc_a, v.exp_cnt);
      @(negedge clk);
      chk("timeout_pulse_once", ep_a, 1'b0);
      chk("timeout_sticky", ec_a, 2'd1);
      return;
    end
    d = (v.fault == 5) ? 64 : 3;
    while (t < d) begin @(negedge clk); t++; end
    score = sc;
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    if (v.exp_err != 2'd0) begin
      chk("bad_pulse_a", ep_a, 1'b1);
      chk("bad_code_a", ec_a, v.exp_err);
      chk("bad_code_b", ec_b, v.exp_err);
      chk("bad_no_valid", bus_a.out_valid | bus_b.out_valid, 1'b0);
      chk("bad_in_ready", bus_a.in_ready, 1'b1);
      @(negedge clk);
      chk("bad_pulse_once", ep_a, 1'b0);
      chk("bad_sticky", ec_a, v.exp_err);
      chk("bad_cnt", fc_a, v.exp_cnt);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < CW && cyc < 500) begin
      if (k == rst_after) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid_a", bus_a.out_valid, 1'b0);
        chk("rst_valid_b", bus_b.out_valid, 1'b0);
        chk("rst_cnt", fc_a, 16'd0);
        chk("rst_in_ready", bus_a.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      chk("drain_valid_a", bus_a.out_valid, 1'b1);
      chk("drain_valid_b", bus_b.out_valid, 1'b1);
      chk("drain_in_ready", bus_a.in_ready, 1'b0);
      chk("data_a", bus_a.out_data, by_rank(CW - k));
      chk("rank_a", bus_a.out_rank, CW - k);
      chk("last_a", bus_a.out_last, k == CW - 1);
      chk("data_b", bus_b.out_data, by_rank(k + 1));
      chk("rank_b", bus_b.out_rank, k + 1);
      chk("last_b", bus_b.out_last, k == CW - 1);
      if (k == 0) chk("first_a_hand", bus_a.out_data, v.first_a);
      if (k == CW - 1) chk("last_a_hand", bus_a.out_data, v.last_a);
      if (k == 0) chk("first_b_hand", bus_b.out_data, v.last_a);
      out_ready = (v.rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus_a.out_valid && out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk("drain_handshakes", k, CW);
    out_ready = 1'b0;
    chk("drain_end_a", bus_a.out_valid, 1'b0);
    chk("drain_end_b", bus_b.out_valid, 1'b0);
    chk("frame_cnt_a", fc_a, v.exp_cnt);
    chk("frame_cnt_b", fc_b, v.exp_cnt);
  endtask

  initial begin
    vec_t hv;
    tbl[0] = '{0, 0, 0, 2'd0, 16'd1, 20'h00100, 20'h00010};
    tbl[1] = '{1, 0, 0, 2'd0, 16'd2, 20'hFFFFF, 20'hFFFF0};
    tbl[2] = '{2, 0, 1, 2'd0, 16'd3, 20'h01004, 20'h00005};
    tbl[3] = '{0, 4, 0, 2'd1, 16'd3, 20'h00000, 20'h00000};
    tbl[4] = '{2, 0, 1, 2'd0, 16'd4, 20'h01004, 20'h00005};
    tbl[5] = '{1, 1, 0, 2'd2, 16'd4, 20'h00000, 20'h00000};
    tbl[6] = '{0, 2, 0, 2'd2, 16'd4, 20'h00000, 20'h00000};
    tbl[7] = '{2, 3, 0, 2'd2, 16'd4, 20'h00000, 20'h00000};
    tbl[8] = '{0, 5, 1, 2'd0, 16'd5, 20'h00100, 20'h00010};

    #1;
    chk("reset_in_ready", bus_a.in_ready, 1'b1);
    chk("reset_out_valid", bus_a.out_valid, 1'b0);
    chk("reset_sort_valid", sv_a, 1'b0);
    chk("reset_sort_data", sd_a, '0);
    chk("reset_err", {ep_a, ec_a}, 3'd0);
    chk("reset_cnt", fc_a, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_frame(tbl[i], -1);

    // score_done outside WAIT must be ignored.
    @(negedge clk);
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    chk("stray_done_valid", bus_a.out_valid, 1'b0);
    chk("stray_done_in_ready", bus_a.in_ready, 1'b1);
    chk("stray_done_err", ep_a, 1'b0);

    // Reset after five outputs, then a clean frame.
    hv = '{0, 0, 0, 2'd0, 16'd0, 20'h00100, 20'h00010};
    run_frame(hv, 5);
    hv = '{1, 0, 0, 2'd0, 16'd1, 20'hFFFFF, 20'hFFFF0};
    run_frame(hv, -1);

    // Soft clear after nine samples discards them.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = DW'(20'hABC00 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", fc_a, 16'd0);
    chk("clr_in_ready", bus_a.in_ready, 1'b1);
    chk("clr_sort_data", sd_a, '0);
    hv = '{2, 0, 1, 2'd0, 16'd1, 20'h01004, 20'h00005};
    run_frame(hv, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
